os_operand_skewer: RTL and testbench

//  Upstream feeder of the output-stationary PE array. Accepts one k-slice per cycle:

---
 rtl/os_operand_skewer.sv | 225 ++++++++++++++++++++++
 tb/tb_os_operand_skewer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_operand_skewer.sv
// ---------------------------------------------------------------------------
// os_operand_skewer
//
// Upstream feeder of an output-stationary PE array. Accepts one k-slice per
// cycle (ROWS activations + COLS weights) over a valid/ready handshake. It
// delays lane i by i+1 cycles so that operands meet diagonally at PE(i,j).
// It also sequences a tile: a reg_clear pulse, streaming, a zero flush long
// enough to drain the array, and then a tile_done pulse.
//
// Optional feature macro: OS_SKEW_STATS_EN
//   When defined, the stall_cnt / bubble_cnt statistics counters are built.
//   When undefined, both ports are tied to zero.
//
// Ports
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_start        begin a tile (sampled only in IDLE and only when not held)
//   i_tile_len     number of k-slices in the tile, sampled with i_start
//   i_hold         global freeze
//   i_in_valid     slice valid
//   o_in_ready     slice accepted when i_in_valid & o_in_ready
//   i_act_in       activations, lane i = [i*WIDTH_A +: WIDTH_A]
//   i_wei_in       weights,     lane j = [j*WIDTH_B +: WIDTH_B]
//   o_act_out      skewed activations to the west edge
//   o_wei_out      skewed weights to the north edge
//   o_pipeline_en  array pipeline enable (= ~i_hold)
//   o_reg_clear    PE accumulator clear
//   o_busy         tile in progress
//   o_tile_done    one-cycle completion pulse
//   o_stall_cnt    hold cycles while busy (statistics build only)
//   o_bubble_cnt   STREAM cycles with no valid input (statistics build only)
// ---------------------------------------------------------------------------
module os_operand_skewer #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16,
    parameter int PE_LAT  = 5,
    parameter int LEN_W   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [LEN_W-1:0]        i_tile_len,
    input  logic                    i_hold,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [ROWS*WIDTH_A-1:0] i_act_in,
    input  logic [COLS*WIDTH_B-1:0] i_wei_in,
    output logic [ROWS*WIDTH_A-1:0] o_act_out,
    output logic [COLS*WIDTH_B-1:0] o_wei_out,
    output logic                    o_pipeline_en,
    output logic                    o_reg_clear,
    output logic                    o_busy,
    output logic                    o_tile_done,
    output logic [31:0]             o_stall_cnt,
    output logic [31:0]             o_bubble_cnt
);

    // Zeros must travel through the longest skew lane plus the PE pipeline
    // before the last real operand has been consumed by the far corner PE.
    localparam int FLUSH_LEN = ROWS + COLS + PE_LAT - 2;
    localparam int FL_W      = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_remain;
    logic [FL_W-1:0]    r_flush;
    logic               w_accept;
    logic               w_last;
    logic               w_busy;
    logic [ROWS*WIDTH_A-1:0] w_act_feed;
    logic [COLS*WIDTH_B-1:0] w_wei_feed;

    assign w_busy     = (r_state != S_IDLE);
    assign w_accept   = (r_state == S_STREAM) & i_in_valid & ~i_hold;
    assign w_last     = w_accept & (r_remain == LEN_W'(1));
    // Non-accepted cycles feed zeros into the lanes; the PE zero-gates them.
    assign w_act_feed = w_accept ? i_act_in : {(ROWS*WIDTH_A){1'b0}};
    assign w_wei_feed = w_accept ? i_wei_in : {(COLS*WIDTH_B){1'b0}};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; hold outranks every transition
    always_comb begin
        w_state_nxt = r_state;
        if (i_hold) begin
            w_state_nxt = r_state;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = (i_tile_len != {LEN_W{1'b0}}) ? S_CLEAR : S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_CLEAR:  w_state_nxt = S_STREAM;
                S_STREAM: w_state_nxt = w_last ? S_FLUSH : S_STREAM;
                S_FLUSH:  w_state_nxt = (r_flush == {FL_W{1'b0}}) ? S_DONE : S_FLUSH;
                S_DONE:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Control outputs decoded from the state register
    always_comb begin
        o_busy        = w_busy;
        o_reg_clear   = (r_state == S_CLEAR);
        o_tile_done   = (r_state == S_DONE);
        o_in_ready    = (r_state == S_STREAM) & ~i_hold;
        o_pipeline_en = ~i_hold;
    end

    // Remaining-slice and flush countdown counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_remain <= {LEN_W{1'b0}};
            r_flush  <= {FL_W{1'b0}};
        end else if (!i_hold) begin
            if ((r_state == S_IDLE) && i_start) begin
                r_remain <= i_tile_len;
            end else if (w_accept) begin
                r_remain <= r_remain - LEN_W'(1);
            end
            if (w_last) begin
                r_flush <= FL_W'(FLUSH_LEN - 1);
            end else if ((r_state == S_FLUSH) && (r_flush != {FL_W{1'b0}})) begin
                r_flush <= r_flush - FL_W'(1);
            end
        end
    end

    // Activation skew: lane i is an (i+1)-deep shift whose last stage is the output register
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_act
        logic [WIDTH_A-1:0] r_sr [0:gi];

        // Shift one activation lane; zeroed on reset and in CLEAR, frozen by hold
        always_ff @(posedge i_clk) begin
            if (i_rst || ((r_state == S_CLEAR) && !i_hold)) begin
                for (int k = 0; k <= gi; k++) begin
                    r_sr[k] <= {WIDTH_A{1'b0}};
                end
            end else if (!i_hold) begin
                r_sr[0] <= w_act_feed[gi*WIDTH_A +: WIDTH_A];
                for (int k = 1; k <= gi; k++) begin
                    r_sr[k] <= r_sr[k-1];
                end
            end
        end

        assign o_act_out[gi*WIDTH_A +: WIDTH_A] = r_sr[gi];
    end

    // Weight skew: same structure as the activation lanes
    for (genvar gj = 0; gj < COLS; gj++) begin : g_wei
        logic [WIDTH_B-1:0] r_sr [0:gj];

        // Shift one weight lane; zeroed on reset and in CLEAR, frozen by hold
        always_ff @(posedge i_clk) begin
            if (i_rst || ((r_state == S_CLEAR) && !i_hold)) begin
                for (int k = 0; k <= gj; k++) begin
                    r_sr[k] <= {WIDTH_B{1'b0}};
                end
            end else if (!i_hold) begin
                r_sr[0] <= w_wei_feed[gj*WIDTH_B +: WIDTH_B];
                for (int k = 1; k <= gj; k++) begin
                    r_sr[k] <= r_sr[k-1];
                end
            end
        end

        assign o_wei_out[gj*WIDTH_B +: WIDTH_B] = r_sr[gj];
    end

`ifdef OS_SKEW_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    // Statistics counters: cleared when a tile's CLEAR cycle proceeds, kept in IDLE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else if ((r_state == S_CLEAR) && !i_hold) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (i_hold && w_busy) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if ((r_state == S_STREAM) && !i_hold && !i_in_valid) begin
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end
        end
    end

    assign o_stall_cnt  = r_stall_cnt;
    assign o_bubble_cnt = r_bubble_cnt;
`else
    assign o_stall_cnt  = 32'd0;
    assign o_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_os_operand_skewer.sv
module tb_os_operand_skewer;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int WA     = 16;
    localparam int WB     = 16;
    localparam int PE_LAT = 5;
    localparam int LEN_W  = 16;
    localparam int FLUSH  = ROWS + COLS + PE_LAT - 2;

    localparam int P_IDLE   = 0;
    localparam int P_CLEAR  = 1;
    localparam int P_STREAM = 2;
    localparam int P_FLUSH  = 3;
    localparam int P_DONE   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [LEN_W-1:0]     tile_len;
    logic                 hold;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*WA-1:0]   act_in;
    logic [COLS*WB-1:0]   wei_in;
    logic [ROWS*WA-1:0]   act_out;
    logic [COLS*WB-1:0]   wei_out;
    logic                 pipeline_en;
    logic                 reg_clear;
    logic                 busy;
    logic                 tile_done;
    logic [31:0]          stall_cnt;
    logic [31:0]          bubble_cnt;

    always #5 clk = ~clk;

    os_operand_skewer #(
        .ROWS(ROWS), .COLS(COLS), .WIDTH_A(WA), .WIDTH_B(WB),
        .PE_LAT(PE_LAT), .LEN_W(LEN_W)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_tile_len(tile_len),
        .i_hold(hold), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_act_in(act_in), .i_wei_in(wei_in),
        .o_act_out(act_out), .o_wei_out(wei_out),
        .o_pipeline_en(pipeline_en), .o_reg_clear(reg_clear), .o_busy(busy),
        .o_tile_done(tile_done), .o_stall_cnt(stall_cnt), .o_bubble_cnt(bubble_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each lane shows what was injected i+1 un-held steps ago; a queue of
    // injected slices (newest first) is the whole skew model.
    int          m_ph    = P_IDLE;
    int          m_left  = 0;
    int          m_fl    = 0;
    int          m_sent  = 0;
    longint      m_stall = 0;
    longint      m_bub   = 0;
    logic [63:0] ha[$];
    logic [63:0] hw[$];

    function automatic logic [63:0] exp_act();
        logic [63:0] v = 64'd0;
        for (int i = 0; i < ROWS; i++)
            if (i < ha.size()) v[i*WA +: WA] = ha[i][i*WA +: WA];
        return v;
    endfunction

    function automatic logic [63:0] exp_wei();
        logic [63:0] v = 64'd0;
        for (int j = 0; j < COLS; j++)
            if (j < hw.size()) v[j*WB +: WB] = hw[j][j*WB +: WB];
        return v;
    endfunction

    function automatic longint sat32(input longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    task automatic model_update();
        logic acc;
        if (rst) begin
            m_ph = P_IDLE; ha.delete(); hw.delete(); m_stall = 0; m_bub = 0;
        end else if (hold) begin
            if (m_ph != P_IDLE) m_stall = sat32(m_stall);
        end else begin
            acc = (m_ph == P_STREAM) && in_valid;
            if (m_ph == P_CLEAR) begin
                m_stall = 0; m_bub = 0; ha.delete(); hw.delete();
            end else begin
                if (m_ph == P_STREAM && !in_valid) m_bub = sat32(m_bub);
                ha.push_front(acc ? act_in : 64'd0);
                hw.push_front(acc ? wei_in : 64'd0);
                if (ha.size() > 8) begin void'(ha.pop_back()); void'(hw.pop_back()); end
            end
            case (m_ph)
                P_IDLE:   if (start) begin
                              if (tile_len != 16'd0) begin m_ph = P_CLEAR; m_left = int'(tile_len); end
                              else m_ph = P_DONE;
                          end
                P_CLEAR:  m_ph = P_STREAM;
                P_STREAM: if (acc) begin
                              m_sent++; m_left--;
                              if (m_left == 0) begin m_ph = P_FLUSH; m_fl = FLUSH; end
                          end
                P_FLUSH:  begin m_fl--; if (m_fl == 0) m_ph = P_DONE; end
                default:  m_ph = P_IDLE;
            endcase
        end
    endtask

    // ---------------- per-cycle driver / checker ----------------
    int       cyc = 0;
    bit       use_rand = 1'b0;
    logic [15:0] rec_a0 [64];
    logic [15:0] rec_a3 [64];
    logic        rec_done [64];
    logic        rec_clr [64];
    logic        rec_busy [64];
    logic        rec_pen [64];
    logic        rec_rdy [64];

    task automatic step();
        @(negedge clk);
        check_eq("busy",  64'(busy),        64'(m_ph != P_IDLE));
        check_eq("clear", 64'(reg_clear),   64'(m_ph == P_CLEAR));
        check_eq("done",  64'(tile_done),   64'(m_ph == P_DONE));
        check_eq("ready", 64'(in_ready),    64'((m_ph == P_STREAM) && !hold));
        check_eq("pen",   64'(pipeline_en), 64'(!hold));
        check_eq("act",   act_out,          exp_act());
        check_eq("wei",   wei_out,          exp_wei());
`ifdef OS_SKEW_STATS_EN
        check_eq("stall", 64'(stall_cnt),   64'(m_stall));
        check_eq("bubble",64'(bubble_cnt),  64'(m_bub));
`else
        check_eq("stall", 64'(stall_cnt),   64'd0);
        check_eq("bubble",64'(bubble_cnt),  64'd0);
`endif
        if (cyc < 64) begin
            rec_a0[cyc] = act_out[15:0];   rec_a3[cyc] = act_out[63:48];
            rec_done[cyc] = tile_done;     rec_clr[cyc] = reg_clear;
            rec_busy[cyc] = busy;          rec_pen[cyc] = pipeline_en;
            rec_rdy[cyc] = in_ready;
        end
        @(posedge clk);
        model_update();
        #1;
        cyc++;
    endtask

    task automatic drv(input logic st, input int len, input logic hv, input logic vld, input logic rs);
        logic [15:0] s;
        start = st; tile_len = 16'(len); hold = hv; in_valid = vld; rst = rs;
        if (use_rand) begin
            act_in = {$urandom, $urandom}; wei_in = {$urandom, $urandom};
        end else begin
            s = 16'(m_sent + 1);
            act_in = {s, s, s, s}; wei_in = {s, s, s, s};
        end
        step();
    endtask

    task automatic full_tile();
        cyc = 0; m_sent = 0;
        drv(1'b1, 3, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c < 19; c++) drv(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check_eq("full_clr_c0",  64'(rec_clr[0]),  64'd0);
        check_eq("full_clr_c1",  64'(rec_clr[1]),  64'd1);
        check_eq("full_rdy_c2",  64'(rec_rdy[2]),  64'd1);
        check_eq("full_a0_c2",   64'(rec_a0[2]),   64'd0);
        check_eq("full_a0_c3",   64'(rec_a0[3]),   64'd1);
        check_eq("full_a0_c5",   64'(rec_a0[5]),   64'd3);
        check_eq("full_a3_c5",   64'(rec_a3[5]),   64'd0);
        check_eq("full_a3_c6",   64'(rec_a3[6]),   64'd1);
        check_eq("full_done_c15",64'(rec_done[15]),64'd0);
        check_eq("full_done_c16",64'(rec_done[16]),64'd1);
        check_eq("full_busy_c16",64'(rec_busy[16]),64'd1);
        check_eq("full_busy_c17",64'(rec_busy[17]),64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; tile_len = 16'd3; hold = 1'b0; in_valid = 1'b0;
        act_in = 64'd0; wei_in = 64'd0;
        @(posedge clk); #1;

        // reset held for three cycles with start asserted
        cyc = 0;
        drv(1'b1, 3, 1'b0, 1'b0, 1'b1);
        drv(1'b1, 3, 1'b0, 1'b0, 1'b1);
        check_eq("rst_busy",  64'(rec_busy[1]), 64'd0);
        check_eq("rst_clr",   64'(rec_clr[1]),  64'd0);
        check_eq("rst_rdy",   64'(rec_rdy[1]),  64'd0);
        check_eq("rst_a0",    64'(rec_a0[1]),   64'd0);

        full_tile();

        // bubble between the two slices
        cyc = 0; m_sent = 0;
        drv(1'b1, 2, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 0, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int c = 5; c < 19; c++) drv(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_eq("bub_a0_c3",   64'(rec_a0[3]),   64'd1);
        check_eq("bub_a0_c4",   64'(rec_a0[4]),   64'd0);
        check_eq("bub_a0_c5",   64'(rec_a0[5]),   64'd2);
        check_eq("bub_done_c15",64'(rec_done[15]),64'd0);
        check_eq("bub_done_c16",64'(rec_done[16]),64'd1);
`ifdef OS_SKEW_STATS_EN
        check_eq("bub_cnt", 64'(bubble_cnt), 64'd1);
`else
        check_eq("bub_cnt", 64'(bubble_cnt), 64'd0);
`endif

        // hold for four cycles mid-STREAM
        cyc = 0; m_sent = 0;
        drv(1'b1, 3, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 0, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int c = 3; c < 7; c++) drv(1'b0, 0, 1'b1, 1'b1, 1'b0);
        for (int c = 7; c < 23; c++) drv(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check_eq("hold_pen_c4",  64'(rec_pen[4]),  64'd0);
        check_eq("hold_rdy_c4",  64'(rec_rdy[4]),  64'd0);
        check_eq("hold_pen_c7",  64'(rec_pen[7]),  64'd1);
        check_eq("hold_a0_c6",   64'(rec_a0[6]),   64'd1);
        check_eq("hold_a0_c8",   64'(rec_a0[8]),   64'd2);
        check_eq("hold_a3_c9",   64'(rec_a3[9]),   64'd0);
        check_eq("hold_a3_c10",  64'(rec_a3[10]),  64'd1);
        check_eq("hold_done_c19",64'(rec_done[19]),64'd0);
        check_eq("hold_done_c20",64'(rec_done[20]),64'd1);
`ifdef OS_SKEW_STATS_EN
        check_eq("hold_stall", 64'(stall_cnt), 64'd4);
`else
        check_eq("hold_stall", 64'(stall_cnt), 64'd0);
`endif

        // zero-length tile
        cyc = 0;
        drv(1'b1, 0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < 4; c++) drv(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_eq("zl_done_c1", 64'(rec_done[1]), 64'd1);
        check_eq("zl_clr_c1",  64'(rec_clr[1]),  64'd0);
        check_eq("zl_done_c2", 64'(rec_done[2]), 64'd0);
        check_eq("zl_busy_c2", 64'(rec_busy[2]), 64'd0);

        // reset in the middle of FLUSH, then a fresh tile
        cyc = 0; m_sent = 0;
        drv(1'b1, 3, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c < 13; c++) drv(1'b0, 0, 1'b0, 1'b1, (c == 8));
        check_eq("abort_busy_c8", 64'(rec_busy[8]), 64'd1);
        check_eq("abort_busy_c9", 64'(rec_busy[9]), 64'd0);
        check_eq("abort_a3_c9",   64'(rec_a3[9]),   64'd0);
        for (int c = 9; c < 13; c++) check_eq("abort_nodone", 64'(rec_done[c]), 64'd0);
        full_tile();

        // randomized traffic against the model
        use_rand = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            drv(($urandom % 4) == 0, int'($urandom % 6), ($urandom % 10) == 0,
                ($urandom % 10) < 7, ($urandom % 300) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
